poke_sprite_mover: RTL and testbench

Parametrised successor to the fixed-position game screen. It holds a movable player window whose position is updated once per frame from the four direction buttons, with a configurable step and clamping at screen edges. It renders the window as a filled box with a border over a background colour. Output goes through a fixed-latency pixel pipeline with matched sync/blank delay, and the block sits between the XVGA timing generator and the VGA output registers.

---
 rtl/poke_pkg.sv | 13 +
 rtl/poke_delay_pipe.sv | 33 +++
 rtl/poke_sprite_mover.sv | 145 ++++++++++++++
 tb/tb_poke_sprite_mover.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/poke_pkg.sv
// Shared types and default screen geometry for the sprite mover.
package poke_pkg;

  localparam int unsigned SCREEN_W = 1024;
  localparam int unsigned SCREEN_H = 768;
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned RGB_W    = 12;

  // RGB444 pixel: r=11:8, g=7:4, b=3:0
  typedef logic [RGB_W-1:0] rgb444_t;

endpackage

// File: rtl/poke_delay_pipe.sv
// Fixed-depth shift register with a synchronous active-low reset value.
// Ports:
//   clk       : clock
//   rst_n     : synchronous active-low reset, loads every stage with i_rst_val
//   i_rst_val : value all stages take on reset
//   i_d       : data in
//   o_q       : data in delayed by DEPTH cycles
module poke_delay_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift chain, flushed to the reset value as a whole
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= i_rst_val;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/poke_sprite_mover.sv
// Movable bordered window over a background, updated once per frame from the
// direction buttons, with a 2-cycle pixel pipeline and matched sync/blank delay.
// Ports:
//   vclk_in, rst_n_in               : pixel clock, synchronous active-low reset
//   up_in/down_in/left_in/right_in  : debounced direction buttons (level)
//   hcount_in, vcount_in            : current pixel coordinates from timing gen
//   hsync_in, vsync_in, blank_in    : timing-gen syncs (active low) and blank
//   phsync_out, pvsync_out, pblank_out : syncs/blank delayed by 2 cycles
//   pixel_out                       : RGB444 pixel aligned with delayed syncs
//   x_out, y_out                    : current window top-left corner
module poke_sprite_mover import poke_pkg::*; #(
  parameter int unsigned SCREEN_W     = poke_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H     = poke_pkg::SCREEN_H,
  parameter int unsigned WIN_W        = 160,
  parameter int unsigned WIN_H        = 144,
  parameter int unsigned START_X      = 432,
  parameter int unsigned START_Y      = 312,
  parameter int unsigned STEP         = 4,
  parameter int unsigned BORDER_W     = 2,
  parameter rgb444_t     BG_COLOR     = 12'h000,
  parameter rgb444_t     FILL_COLOR   = 12'hFFF,
  parameter rgb444_t     BORDER_COLOR = 12'hF00
) (
  input  logic                vclk_in,
  input  logic                rst_n_in,
  input  logic                up_in,
  input  logic                down_in,
  input  logic                left_in,
  input  logic                right_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                blank_in,
  output logic                phsync_out,
  output logic                pvsync_out,
  output logic                pblank_out,
  output rgb444_t             pixel_out,
  output logic [HCOUNT_W-1:0] x_out,
  output logic [VCOUNT_W-1:0] y_out
);

  localparam int unsigned X_MAX = SCREEN_W - WIN_W;
  localparam int unsigned Y_MAX = SCREEN_H - WIN_H;

  logic [HCOUNT_W-1:0] r_x;
  logic [VCOUNT_W-1:0] r_y;
  logic [HCOUNT_W-1:0] w_x_next;
  logic [VCOUNT_W-1:0] w_y_next;
  logic [HCOUNT_W:0]   w_x_inc;
  logic [HCOUNT_W:0]   w_x_dec;
  logic [VCOUNT_W:0]   w_y_inc;
  logic [VCOUNT_W:0]   w_y_dec;
  logic                w_strobe;

  logic [HCOUNT_W-1:0] w_dx;
  logic [VCOUNT_W-1:0] w_dy;
  logic                w_in_win;
  logic                w_in_border;
  logic                r_s1_in_win;
  logic                r_s1_in_border;
  logic                r_s1_blank;
  rgb444_t             r_pixel;

  assign w_strobe = (hcount_in == '0) && (vcount_in == '0);

  // One-bit-wider intermediates: a set MSB on the decrement means underflow
  assign w_x_inc = (HCOUNT_W+1)'(r_x) + (HCOUNT_W+1)'(STEP);
  assign w_x_dec = (HCOUNT_W+1)'(r_x) - (HCOUNT_W+1)'(STEP);
  assign w_y_inc = (VCOUNT_W+1)'(r_y) + (VCOUNT_W+1)'(STEP);
  assign w_y_dec = (VCOUNT_W+1)'(r_y) - (VCOUNT_W+1)'(STEP);

  // Next position with clamping; opposing buttons cancel
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (right_in && !left_in) begin
      w_x_next = (w_x_inc > (HCOUNT_W+1)'(X_MAX)) ? HCOUNT_W'(X_MAX) : w_x_inc[HCOUNT_W-1:0];
    end else if (left_in && !right_in) begin
      w_x_next = w_x_dec[HCOUNT_W] ? '0 : w_x_dec[HCOUNT_W-1:0];
    end
    if (down_in && !up_in) begin
      w_y_next = (w_y_inc > (VCOUNT_W+1)'(Y_MAX)) ? VCOUNT_W'(Y_MAX) : w_y_inc[VCOUNT_W-1:0];
    end else if (up_in && !down_in) begin
      w_y_next = w_y_dec[VCOUNT_W] ? '0 : w_y_dec[VCOUNT_W-1:0];
    end
  end

  // Position register, only moves at the top-left pixel of a frame
  always_ff @(posedge vclk_in) begin
    if (!rst_n_in) begin
      r_x <= HCOUNT_W'(START_X);
      r_y <= VCOUNT_W'(START_Y);
    end else if (w_strobe) begin
      r_x <= w_x_next;
      r_y <= w_y_next;
    end
  end

  assign x_out = r_x;
  assign y_out = r_y;

  // Offsets wrap when left/above the window, so one unsigned compare suffices
  assign w_dx     = hcount_in - r_x;
  assign w_dy     = vcount_in - r_y;
  assign w_in_win = (w_dx < HCOUNT_W'(WIN_W)) && (w_dy < VCOUNT_W'(WIN_H));
  assign w_in_border = w_in_win &&
                       ((w_dx < HCOUNT_W'(BORDER_W)) ||
                        (w_dx >= HCOUNT_W'(WIN_W - BORDER_W)) ||
                        (w_dy < VCOUNT_W'(BORDER_W)) ||
                        (w_dy >= VCOUNT_W'(WIN_H - BORDER_W)));

  // Render pipeline: stage 1 classifies, stage 2 picks the colour
  always_ff @(posedge vclk_in) begin
    if (!rst_n_in) begin
      r_s1_in_win    <= 1'b0;
      r_s1_in_border <= 1'b0;
      r_s1_blank     <= 1'b1;
      r_pixel        <= '0;
    end else begin
      r_s1_in_win    <= w_in_win;
      r_s1_in_border <= w_in_border;
      r_s1_blank     <= blank_in;
      if (r_s1_blank)          r_pixel <= '0;
      else if (r_s1_in_border) r_pixel <= BORDER_COLOR;
      else if (r_s1_in_win)    r_pixel <= FILL_COLOR;
      else                     r_pixel <= BG_COLOR;
    end
  end

  assign pixel_out = r_pixel;

  // Sync/blank delay matched to the render pipeline
  poke_delay_pipe #(
    .WIDTH(3),
    .DEPTH(2)
  ) u_sync_pipe (
    .clk       (vclk_in),
    .rst_n     (rst_n_in),
    .i_rst_val (3'b111),
    .i_d       ({hsync_in, vsync_in, blank_in}),
    .o_q       ({phsync_out, pvsync_out, pblank_out})
  );

endmodule

// File: tb/tb_poke_sprite_mover.sv
module tb_poke_sprite_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up, down, left, right;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic        phsync, pvsync, pblank;
  logic [11:0] pixel;
  logic [10:0] x;
  logic [9:0]  y;
  logic        phsync2, pvsync2, pblank2;
  logic [11:0] pixel2;
  logic [10:0] x2;
  logic [9:0]  y2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  poke_sprite_mover dut (
    .vclk_in(clk), .rst_n_in(rst_n),
    .up_in(up), .down_in(down), .left_in(left), .right_in(right),
    .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
    .phsync_out(phsync), .pvsync_out(pvsync), .pblank_out(pblank),
    .pixel_out(pixel), .x_out(x), .y_out(y)
  );

  // Second instance placed near the edges to reach the clamp cases
  poke_sprite_mover #(.START_X(2), .START_Y(622)) dut2 (
    .vclk_in(clk), .rst_n_in(rst_n),
    .up_in(up), .down_in(down), .left_in(left), .right_in(right),
    .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
    .phsync_out(phsync2), .pvsync_out(pvsync2), .pblank_out(pblank2),
    .pixel_out(pixel2), .x_out(x2), .y_out(y2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe cycle with the given buttons, then one idle non-strobe cycle
  task automatic strobe(input logic u, input logic d, input logic l, input logic r);
    up = u; down = d; left = l; right = r;
    hcount = 11'd0; vcount = 10'd0;
    tick();
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    hcount = 11'd1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    hcount = 11'd5; vcount = 10'd5;
    hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
    repeat (3) tick();
    n_tests++; if (x !== 11'd432) begin n_fail++; $display("FAIL reset_x got %0d exp 432", x); end
    n_tests++; if (y !== 10'd312) begin n_fail++; $display("FAIL reset_y got %0d exp 312", y); end
    n_tests++; if (pixel !== 12'h000) begin n_fail++; $display("FAIL reset_pixel got %h exp 000", pixel); end
    n_tests++; if ({phsync, pvsync, pblank} !== 3'b111) begin n_fail++; $display("FAIL reset_sync got %b exp 111", {phsync, pvsync, pblank}); end
    n_tests++; if (x2 !== 11'd2) begin n_fail++; $display("FAIL reset_x2 got %0d exp 2", x2); end
    hsync = 1'b1; vsync = 1'b1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pixels();
    int vh [14];
    int vv [14];
    int vb [14];
    int ve [14];
    vh = '{432, 500, 100, 500, 591, 592, 500, 500, 500, 433, 434, 589, 590, 432};
    vv = '{400, 400, 400, 400, 400, 400, 312, 455, 456, 313, 314, 453, 400, 311};
    vb = '{0,   0,   0,   1,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0};
    ve = '{'hF00, 'hFFF, 'h000, 'h000, 'hF00, 'h000, 'hF00, 'hF00, 'h000,
           'hF00, 'hFFF, 'hFFF, 'hF00, 'h000};
    for (int k = 0; k < 15; k++) begin
      if (k < 14) begin
        hcount = 11'(vh[k]); vcount = 10'(vv[k]); blank = vb[k][0];
      end else begin
        hcount = 11'd100; vcount = 10'd400; blank = 1'b0;
      end
      tick();
      if (k >= 1) begin
        n_tests++;
        if (pixel !== 12'(ve[k-1])) begin
          n_fail++;
          $display("FAIL pixel_vec%0d h=%0d v=%0d got %h exp %h", k-1, vh[k-1], vv[k-1], pixel, 12'(ve[k-1]));
        end
      end
    end
  endtask

  task automatic test_sync_align();
    logic [2:0] prev;
    logic [2:0] cur;
    hcount = 11'd100; vcount = 10'd400;
    prev = 3'b000;
    for (int k = 0; k < 24; k++) begin
      cur = 3'($urandom_range(0, 7));
      {hsync, vsync, blank} = cur;
      tick();
      if (k >= 1) begin
        n_tests++;
        if ({phsync, pvsync, pblank} !== prev) begin
          n_fail++;
          $display("FAIL sync_align_%0d got %b exp %b", k, {phsync, pvsync, pblank}, prev);
        end
      end
      prev = cur;
    end
    hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
    tick();
  endtask

  task automatic test_move_right();
    repeat (3) strobe(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (x !== 11'd444) begin n_fail++; $display("FAIL right3_x got %0d exp 444", x); end
    n_tests++; if (y !== 10'd312) begin n_fail++; $display("FAIL right3_y got %0d exp 312", y); end
    strobe(1'b0, 1'b0, 1'b1, 1'b1);
    n_tests++; if (x !== 11'd444) begin n_fail++; $display("FAIL left_right_x got %0d exp 444", x); end
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++; if (x !== 11'd448) begin n_fail++; $display("FAIL diag_x got %0d exp 448", x); end
    n_tests++; if (y !== 10'd316) begin n_fail++; $display("FAIL diag_y got %0d exp 316", y); end
    n_tests++; if (y2 !== 10'd624) begin n_fail++; $display("FAIL clamp_bottom_y2 got %0d exp 624", y2); end
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (y !== 10'd320) begin n_fail++; $display("FAIL down_y got %0d exp 320", y); end
    n_tests++; if (y2 !== 10'd624) begin n_fail++; $display("FAIL clamp_bottom_hold_y2 got %0d exp 624", y2); end
  endtask

  task automatic test_clamp_left();
    repeat (5) strobe(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (x2 !== 11'd0) begin n_fail++; $display("FAIL clamp_left_x2 got %0d exp 0", x2); end
    n_tests++; if (x !== 11'd428) begin n_fail++; $display("FAIL left5_x got %0d exp 428", x); end
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (x2 !== 11'd0) begin n_fail++; $display("FAIL clamp_left_hold_x2 got %0d exp 0", x2); end
    // Window at the left screen edge still draws its left border
    hcount = 11'd0; vcount = 10'd700; blank = 1'b0;
    tick(); tick();
    n_tests++; if (pixel2 !== 12'hF00) begin n_fail++; $display("FAIL edge_border_pixel2 got %h exp F00", pixel2); end
    hcount = 11'd1; vcount = 10'd0;
  endtask

  task automatic test_clamp_right();
    int max_x;
    max_x = 0;
    for (int k = 0; k < 115; k++) begin
      strobe(1'b0, 1'b0, 1'b0, 1'b1);
      if (int'(x) > max_x) max_x = int'(x);
    end
    n_tests++; if (x !== 11'd864) begin n_fail++; $display("FAIL clamp_right_x got %0d exp 864", x); end
    n_tests++; if (max_x > 864) begin n_fail++; $display("FAIL clamp_right_max got %0d exp <=864", max_x); end
    n_tests++; if (y !== 10'd320) begin n_fail++; $display("FAIL clamp_right_y got %0d exp 320", y); end
  endtask

  task automatic test_nonstrobe();
    down = 1'b1; left = 1'b1;
    hcount = 11'd5; vcount = 10'd0;
    repeat (5) tick();
    hcount = 11'd0; vcount = 10'd7;
    repeat (5) tick();
    down = 1'b0; left = 1'b0;
    hcount = 11'd1;
    tick();
    n_tests++; if (y !== 10'd320) begin n_fail++; $display("FAIL nonstrobe_y got %0d exp 320", y); end
    n_tests++; if (x !== 11'd864) begin n_fail++; $display("FAIL nonstrobe_x got %0d exp 864", x); end
  endtask

  task automatic test_reset_midframe();
    hcount = 11'd300; vcount = 10'd200;
    hsync = 1'b0; blank = 1'b0;
    rst_n = 1'b0;
    tick();
    n_tests++; if (x !== 11'd432) begin n_fail++; $display("FAIL midrst_x got %0d exp 432", x); end
    n_tests++; if (y !== 10'd312) begin n_fail++; $display("FAIL midrst_y got %0d exp 312", y); end
    n_tests++; if ({phsync, pblank} !== 2'b11) begin n_fail++; $display("FAIL midrst_sync got %b exp 11", {phsync, pblank}); end
    n_tests++; if (pixel !== 12'h000) begin n_fail++; $display("FAIL midrst_pixel got %h exp 000", pixel); end
    rst_n = 1'b1; hsync = 1'b1;
    tick();
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++; if (y !== 10'd308) begin n_fail++; $display("FAIL post_rst_up_y got %0d exp 308", y); end
    n_tests++; if (x !== 11'd432) begin n_fail++; $display("FAIL post_rst_up_x got %0d exp 432", x); end
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++; if (x !== 11'd436) begin n_fail++; $display("FAIL post_rst_diag_x got %0d exp 436", x); end
    n_tests++; if (y !== 10'd312) begin n_fail++; $display("FAIL post_rst_diag_y got %0d exp 312", y); end
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_sync_align();
    test_move_right();
    test_clamp_left();
    test_clamp_right();
    test_nonstrobe();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
